// File: rtl/truth_table_evaluator.sv
// Sweeps a 4-input logic cell through every input vector and scores its output
// against an expected truth table. Optional early abort: TTE_EARLY_ABORT_EN.
module truth_table_evaluator #(
  parameter int unsigned N_IN   = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   expected,
  input  logic                 dut_out,
  output logic [N_IN-1:0]      dut_in,
  output logic                 busy,
  output logic                 done,
  output logic [N_IN:0]        fitness,
  output logic [2**N_IN-1:0]   captured,
  output logic                 fail_valid,
  output logic [N_IN-1:0]      first_fail_idx
);

  localparam int unsigned   TW       = 2**N_IN;
  localparam logic [N_IN:0] LAST_IDX = (N_IN+1)'(TW-1);
  localparam logic [3:0]    SETTLE_C = 4'(SETTLE);
`ifdef TTE_EARLY_ABORT_EN
  localparam bit EARLY_ABORT = 1'b1;
`else
  localparam bit EARLY_ABORT = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  state_t          state, state_nxt;
  logic [N_IN:0]   idx;
  logic [3:0]      settle_cnt;
  logic [TW-1:0]   expected_q;
  logic            sample, is_last, mismatch, finish;

  assign dut_in = idx[N_IN-1:0];

  always_comb begin
    sample   = (state == DRIVE) && (settle_cnt == SETTLE_C);
    is_last  = (idx == LAST_IDX);
    mismatch = (dut_out != expected_q[idx[N_IN-1:0]]);
    finish   = sample && (is_last || (EARLY_ABORT && mismatch));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = DRIVE;
      DRIVE:   if (finish) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == DRIVE);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx            <= '0;
      settle_cnt     <= '0;
      expected_q     <= '0;
      fitness        <= '0;
      captured       <= '0;
      fail_valid     <= 1'b0;
      first_fail_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            expected_q     <= expected;
            fitness        <= '0;
            captured       <= '0;
            fail_valid     <= 1'b0;
            first_fail_idx <= '0;
            idx            <= '0;
            settle_cnt     <= '0;
          end
        end
        DRIVE: begin
          if (sample) begin
            captured[idx[N_IN-1:0]] <= dut_out;
            if (!mismatch) begin
              fitness <= fitness + 1'b1;
            end else if (!fail_valid) begin
              fail_valid     <= 1'b1;
              first_fail_idx <= idx[N_IN-1:0];
            end
            // idx stays on the final (or failing) vector so dut_in holds in IDLE
            if (!finish) begin
              idx        <= idx + 1'b1;
              settle_cnt <= '0;
            end
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_evaluator.sv
// Directed bench for truth_table_evaluator: SETTLE=1 and SETTLE=0 instances,
// driven by behavioural AND4 / tied-high / one-cycle-delayed cell models.
module tb_truth_table_evaluator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        use0 = 1'b0;
  logic [15:0] expected = '0;
  int          mode = 0;
  int          tests = 0;
  int          fails = 0;

  logic        start_a, start_b, out_a, out_b, del_a, del_b;
  logic [3:0]  din_a, din_b, ffi_a, ffi_b;
  logic        busy_a, busy_b, done_a, done_b, fv_a, fv_b;
  logic [4:0]  fit_a, fit_b;
  logic [15:0] cap_a, cap_b;

  logic [3:0]  din, ffi;
  logic        busy, done, fv;
  logic [4:0]  fit;
  logic [15:0] cap;

  always #5 clk = ~clk;

  assign start_a = start & ~use0;
  assign start_b = start & use0;

  always_ff @(posedge clk) begin
    del_a <= &din_a;
    del_b <= &din_b;
  end

  always_comb begin
    out_a = (mode == 0) ? &din_a : (mode == 1) ? 1'b1 : del_a;
    out_b = (mode == 0) ? &din_b : (mode == 1) ? 1'b1 : del_b;
    din  = use0 ? din_b  : din_a;
    ffi  = use0 ? ffi_b  : ffi_a;
    busy = use0 ? busy_b : busy_a;
    done = use0 ? done_b : done_a;
    fv   = use0 ? fv_b   : fv_a;
    fit  = use0 ? fit_b  : fit_a;
    cap  = use0 ? cap_b  : cap_a;
  end

  truth_table_evaluator #(.N_IN(4), .SETTLE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .expected(expected), .dut_out(out_a),
    .dut_in(din_a), .busy(busy_a), .done(done_a), .fitness(fit_a), .captured(cap_a),
    .fail_valid(fv_a), .first_fail_idx(ffi_a));

  truth_table_evaluator #(.N_IN(4), .SETTLE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .expected(expected), .dut_out(out_b),
    .dut_in(din_b), .busy(busy_b), .done(done_b), .fitness(fit_b), .captured(cap_b),
    .fail_valid(fv_b), .first_fail_idx(ffi_b));

  // Pulses start in cycle 0, optionally re-pulses it, scrambles expected in cycle 3,
  // and optionally checks the dut_in staircase for the given settle value.
  task automatic run_sweep(input logic [15:0] exp, input int rs1, input int rs2,
                           input int chk_settle, output int dcyc, output int dcnt);
    @(negedge clk);
    expected = exp;
    start = 1'b1;
    dcyc = 0;
    dcnt = 0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      start = (c == rs1) || (c == rs2);
      if (c == 3) expected = ~exp;
      if (done) begin
        dcnt++;
        if (dcyc == 0) dcyc = c;
      end
      if (chk_settle >= 0 && c <= 16 * (chk_settle + 1)) begin
        tests++;
        if (din !== 4'((c - 1) / (chk_settle + 1))) begin
          fails++;
          $display("FAIL dut_in_step cycle %0d: got %0d want %0d", c, din, (c - 1) / (chk_settle + 1));
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({din_a, fit_a, cap_a, ffi_a, busy_a, done_a, fv_a} !== '0) begin
      fails++;
      $display("FAIL reset_a: got din=%h fit=%0d cap=%h ffi=%0d busy=%b done=%b fv=%b want all 0",
               din_a, fit_a, cap_a, ffi_a, busy_a, done_a, fv_a);
    end
    tests++;
    if ({din_b, fit_b, cap_b, ffi_b, busy_b, done_b, fv_b} !== '0) begin
      fails++;
      $display("FAIL reset_b: got din=%h fit=%0d cap=%h ffi=%0d busy=%b done=%b fv=%b want all 0",
               din_b, fit_b, cap_b, ffi_b, busy_b, done_b, fv_b);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_and4_match;
    int dc, dn;
    use0 = 1'b0; mode = 0;
    run_sweep(16'h8000, -1, -1, 1, dc, dn);
    tests++; if (dc !== 33 || dn !== 1) begin fails++; $display("FAIL and4_done: got cycle %0d count %0d want 33 1", dc, dn); end
    tests++; if (fit !== 5'd16) begin fails++; $display("FAIL and4_fitness: got %0d want 16", fit); end
    tests++; if (cap !== 16'h8000) begin fails++; $display("FAIL and4_captured: got %h want 8000", cap); end
    tests++; if (fv !== 1'b0 || ffi !== 4'd0) begin fails++; $display("FAIL and4_fail: got fv=%b ffi=%0d want 0 0", fv, ffi); end
    tests++; if (busy !== 1'b0 || din !== 4'd15) begin fails++; $display("FAIL and4_idle: got busy=%b din=%0d want 0 15", busy, din); end
  endtask

  task automatic test_and4_mismatch;
    int dc, dn;
    use0 = 1'b0; mode = 0;
    run_sweep(16'h0000, -1, -1, -1, dc, dn);
    tests++; if (dc !== 33 || dn !== 1) begin fails++; $display("FAIL mism_done: got cycle %0d count %0d want 33 1", dc, dn); end
    tests++; if (fit !== 5'd15) begin fails++; $display("FAIL mism_fitness: got %0d want 15", fit); end
    tests++; if (fv !== 1'b1 || ffi !== 4'd15) begin fails++; $display("FAIL mism_fail: got fv=%b ffi=%0d want 1 15", fv, ffi); end
    tests++; if (cap !== 16'h8000) begin fails++; $display("FAIL mism_captured: got %h want 8000", cap); end
  endtask

  task automatic test_tied_high;
    int dc, dn;
    use0 = 1'b0; mode = 1;
    run_sweep(16'h8000, -1, -1, -1, dc, dn);
`ifdef TTE_EARLY_ABORT_EN
    tests++; if (dc !== 3 || dn !== 1) begin fails++; $display("FAIL tied_done: got cycle %0d count %0d want 3 1", dc, dn); end
    tests++; if (fit !== 5'd0) begin fails++; $display("FAIL tied_fitness: got %0d want 0", fit); end
    tests++; if (cap !== 16'h0001) begin fails++; $display("FAIL tied_captured: got %h want 0001", cap); end
`else
    tests++; if (dc !== 33 || dn !== 1) begin fails++; $display("FAIL tied_done: got cycle %0d count %0d want 33 1", dc, dn); end
    tests++; if (fit !== 5'd1) begin fails++; $display("FAIL tied_fitness: got %0d want 1", fit); end
    tests++; if (cap !== 16'hFFFF) begin fails++; $display("FAIL tied_captured: got %h want FFFF", cap); end
`endif
    tests++; if (fv !== 1'b1 || ffi !== 4'd0) begin fails++; $display("FAIL tied_fail: got fv=%b ffi=%0d want 1 0", fv, ffi); end
  endtask

  task automatic test_restart_ignored;
    int dc, dn;
    use0 = 1'b0; mode = 0;
    run_sweep(16'h8000, 5, 20, -1, dc, dn);
    tests++; if (dc !== 33 || dn !== 1) begin fails++; $display("FAIL restart_done: got cycle %0d count %0d want 33 1", dc, dn); end
    tests++; if (fit !== 5'd16 || cap !== 16'h8000 || fv !== 1'b0) begin
      fails++; $display("FAIL restart_result: got fit=%0d cap=%h fv=%b want 16 8000 0", fit, cap, fv);
    end
  endtask

  task automatic test_reset_mid_sweep;
    int dn, dc;
    use0 = 1'b0; mode = 0;
    @(negedge clk);
    expected = 16'h0001;
    start = 1'b1;
    dn = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) dn++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tests++;
    if ({din_a, fit_a, cap_a, ffi_a, busy_a, done_a, fv_a} !== '0) begin
      fails++;
      $display("FAIL midreset_outputs: got din=%h fit=%0d cap=%h ffi=%0d busy=%b done=%b fv=%b want all 0",
               din_a, fit_a, cap_a, ffi_a, busy_a, done_a, fv_a);
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) dn++;
    end
`ifndef TTE_EARLY_ABORT_EN
    tests++; if (dn !== 0) begin fails++; $display("FAIL midreset_no_done: got %0d done pulses want 0", dn); end
`endif
    run_sweep(16'h8000, -1, -1, -1, dc, dn);
    tests++; if (dc !== 33 || dn !== 1 || fit !== 5'd16 || cap !== 16'h8000) begin
      fails++; $display("FAIL midreset_rerun: got cycle=%0d count=%0d fit=%0d cap=%h want 33 1 16 8000", dc, dn, fit, cap);
    end
  endtask

  task automatic test_settle0;
    int dc, dn;
    use0 = 1'b1; mode = 0;
    run_sweep(16'h8000, -1, -1, 0, dc, dn);
    tests++; if (dc !== 17 || dn !== 1) begin fails++; $display("FAIL s0_done: got cycle %0d count %0d want 17 1", dc, dn); end
    tests++; if (fit !== 5'd16 || fv !== 1'b0) begin fails++; $display("FAIL s0_fitness: got fit=%0d fv=%b want 16 0", fit, fv); end
  endtask

  task automatic test_delayed_cell;
    int dc, dn;
    // SETTLE=0: each sample sees the previous vector (first one sees 15 left from the prior sweep)
    use0 = 1'b1; mode = 2;
    run_sweep(16'h8000, -1, -1, -1, dc, dn);
    tests++; if (fv !== 1'b1 || ffi !== 4'd0) begin fails++; $display("FAIL delay_s0_fail: got fv=%b ffi=%0d want 1 0", fv, ffi); end
    tests++; if (cap !== 16'h0001) begin fails++; $display("FAIL delay_s0_captured: got %h want 0001", cap); end
`ifdef TTE_EARLY_ABORT_EN
    tests++; if (fit !== 5'd0 || dc !== 2) begin fails++; $display("FAIL delay_s0_fitness: got fit=%0d cycle=%0d want 0 2", fit, dc); end
`else
    tests++; if (fit !== 5'd14 || dc !== 17) begin fails++; $display("FAIL delay_s0_fitness: got fit=%0d cycle=%0d want 14 17", fit, dc); end
`endif
    use0 = 1'b0;
    run_sweep(16'h8000, -1, -1, -1, dc, dn);
    tests++; if (fit !== 5'd16 || fv !== 1'b0 || cap !== 16'h8000 || dc !== 33) begin
      fails++; $display("FAIL delay_s1: got fit=%0d fv=%b cap=%h cycle=%0d want 16 0 8000 33", fit, fv, cap, dc);
    end
  endtask

  initial begin
    test_reset;
    test_and4_match;
    test_and4_mismatch;
    test_tied_high;
    test_restart_ignored;
    test_reset_mid_sweep;
    test_settle0;
    test_delayed_cell;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/truth_table_evaluator.md
Name: truth_table_evaluator

Overview:
- Sequencer that exhaustively sweeps a 4-input combinational logic block under test through all 2^N_IN input vectors.
- Samples the block's single output for each vector and compares it against an expected truth table.
- Reports a match count (fitness), the captured truth table and the index of the first mismatch.
- Sits between the candidate-circuit evaluation harness and each evolved or hand-written logic cell.

Parameters:
- N_IN, 4, number of DUT inputs; table width is 2^N_IN.
- SETTLE, 1, extra cycles each vector is held before sampling; legal range 0..15.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  begin a sweep; sampled only in IDLE.
- expected  in  2^N_IN  expected output per vector; bit i corresponds to vector i. Registered at start.
- dut_out  in  1  output of logic under test.
- dut_in  out  N_IN  vector driven to logic under test.
- busy  out  1  high while sweeping.
- done  out  1  one-cycle pulse when the sweep ends.
- fitness  out  N_IN+1  number of matching vectors, 0..2^N_IN.
- captured  out  2^N_IN  sampled dut_out per vector.
- fail_valid  out  1  at least one mismatch seen in the last sweep.
- first_fail_idx  out  N_IN  lowest vector index that mismatched.

Behaviour:
- Reset (synchronous, rst_n low at a rising edge): state=IDLE; dut_in, fitness, captured, first_fail_idx all 0; busy, done, fail_valid 0. Reset mid-sweep aborts immediately, with no done pulse.
- States: IDLE, DRIVE, DONE.
- IDLE:
  - On start=1: latch expected; clear fitness, captured, fail_valid and first_fail_idx.
  - Set idx=0, dut_in=0, settle_cnt=0, busy=1; go to DRIVE.
- DRIVE:
  - dut_in=idx is held stable for SETTLE+1 cycles.
  - settle_cnt increments each cycle.
  - At the edge where settle_cnt==SETTLE: captured[idx]<=dut_out.
  - If dut_out==expected_q[idx]: fitness+=1.
  - Else, if fail_valid==0: fail_valid<=1 and first_fail_idx<=idx.
  - Then, if idx==2^N_IN-1: go to DONE. Otherwise idx+=1 (dut_in follows) and settle_cnt=0.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- Latency: done is high in cycle 1+2^N_IN*(SETTLE+1) counted from the cycle in which start is sampled (cycle 0). Default: cycle 33.
- Result hold: results are held stable from DONE until the next accepted start. dut_in holds its last vector in IDLE.
- start while busy or in DONE: ignored, with no effect on the running sweep.
- start held high continuously: a new sweep begins on the first IDLE cycle after DONE.
- Width rules:
  - fitness never wraps; max 2^N_IN fits in N_IN+1 bits.
  - idx is N_IN+1 bits internally to detect the end cleanly; dut_in is its low N_IN bits.
- expected changes during a sweep have no effect, because the latched copy is used.

Optional Feature:
- Macro: TTE_EARLY_ABORT_EN.
- Defined: on the first mismatch the sweep ends.
  - The FSM goes to DONE at the next edge instead of advancing idx.
  - fitness holds the count of matches before the failure.
  - captured bits above first_fail_idx remain 0.
  - Done latency shrinks to 1+(first_fail_idx+1)*(SETTLE+1).
- Undefined: the full sweep always runs, as described above.
- Ports are identical in both builds.

Test Plan:
- AND4 model as DUT, expected=16'h8000, SETTLE=1, start pulse -> done at cycle 33; fitness=16; captured=16'h8000; fail_valid=0; first_fail_idx=0. dut_in steps 0..15, each held 2 cycles.
- AND4 model, expected=16'h0000 -> fitness=15; fail_valid=1; first_fail_idx=15; captured=16'h8000.
- DUT tied to 1, expected=16'h8000 -> fitness=1; first_fail_idx=0; captured=16'hFFFF. With TTE_EARLY_ABORT_EN: done at cycle 3, fitness=0, captured=16'h0001.
- start re-pulsed at cycles 5 and 20 of an AND4 sweep -> ignored; single done at cycle 33; results identical to the first scenario.
- rst_n low for one edge at cycle 10 of a sweep -> next cycle all outputs 0 and state IDLE; no done. A following start completes a normal sweep with correct results.
- SETTLE=0 with AND4 and expected=16'h8000 -> done at cycle 17; fitness=16. Also a DUT model with 1-cycle output delay and SETTLE=0 -> mismatches detected. The same model with SETTLE=1 -> fitness=16.
